reservoir_sequencer: RTL and testbench
======================================

// Module: reservoir_sequencer
// PURPOSE
// Front-end controller for the hybrid DFR reservoir. Accepts input samples, multiplies each by a
// per-virtual-node mask and drives reservoir din/en once per virtual node, handshaking on
// reservoir_valid. After all nodes are updated it walks node_sel and streams every node state out.
// Also clears the reservoir state through load_node on request. Sits between the AXI-side
// sample/config logic and the reservoir ASIC wrapper.
// PARAMETERS
// NUM_VIRTUAL_NODES  10    virtual nodes per sample; node index width NW=$clog2(NUM_VIRTUAL_NODES)
// DATA_WIDTH         32    width of reservoir din
// NODE_DATA_WIDTH    12    width of node state / load data
// INPUT_WIDTH        16    width of input sample u
// MASK_WIDTH         8     width of unsigned mask entry
// TIMEOUT_CYCLES     4096  WAIT watchdog limit; used only with RES_SEQ_TIMEOUT_EN
// PORTS
// clk            in   1     single clock
// rst            in   1     synchronous, active-high reset
// in_valid       in   1     sample valid
// in_ready       out  1     sample ready
// in_data        in   INPUT_WIDTH      sample u (unsigned)
// clear_req      in   1     pulse: zero all node states
// cfg_mask_we    in   1     mask write strobe
// cfg_mask_addr  in   NW    mask entry index
// cfg_mask_data  in   MASK_WIDTH       mask value
// cfg_eta        in   4     feedback scaling, latched per sample
// res_en         out  1     one-cycle reservoir update pulse
// res_din        out  DATA_WIDTH       masked input to reservoir
// res_eta        out  4     eta to reservoir
// res_valid      in   1     reservoir idle/valid
// res_load_node  out  1     node load strobe
// res_load_din   out  NODE_DATA_WIDTH  node load data (always 0)
// res_node_sel   out  NW    node select (load and readout)
// res_node_dout  in   NODE_DATA_WIDTH  selected node state
// out_valid      out  1     node-state valid
// out_ready      in   1     downstream ready
// out_data       out  NODE_DATA_WIDTH  node state
// out_last       out  1     high with final node of a sample
// busy           out  1     state != IDLE
// timeout_err    out  1     sticky watchdog error
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 (in_ready 1 in IDLE unless clear_req); mask RAM all 0;
//   indices 0; timeout_err 0. Reset mid-operation aborts; no partial output stream completes.
// - FSM: IDLE, CLEAR, DRIVE, WAIT, READ, EMIT.
// - IDLE: in_ready=!clear_req. clear_req wins over in_valid in the same cycle -> CLEAR.
//   Handshake -> latch u, res_eta<=cfg_eta, idx=0, DRIVE. Mask writes honoured only in IDLE;
//   all other writes are dropped. Write to addr>=NUM_VIRTUAL_NODES is ignored.
// - CLEAR: per cycle res_load_node=1, res_node_sel=idx, res_load_din=0; idx++;
//   after idx=N-1 -> IDLE. N cycles.
// - DRIVE: res_din=zero-ext((u*mask[idx])>>MASK_WIDTH) (product INPUT_WIDTH+MASK_WIDTH bits,
//   keep upper INPUT_WIDTH); res_en=1 exactly one cycle -> WAIT.
// - WAIT: first cycle is blanking (res_valid ignored). Afterwards res_valid=1 -> idx++, DRIVE;
//   or on idx=N-1 -> idx=0, READ.
// - READ: res_node_sel=idx; out_data<=res_node_dout, out_valid<=1, out_last<=(idx==N-1) -> EMIT.
// - EMIT: hold out_* stable while !out_ready. On out_ready: out_valid<=0; last -> IDLE,
//   else idx++, READ.
// - Drive latency: each node costs >= 3 cycles plus reservoir time. Readout takes 2 cycles/node
//   with out_ready held at 1.
// CONFIGURATION
// RES_SEQ_TIMEOUT_EN defined: a WAIT counter resets on WAIT entry. Reaching TIMEOUT_CYCLES
// without res_valid sets timeout_err (sticky until rst) and goes to IDLE, with no readout for
// that sample. Undefined: no counter; timeout_err tied 0; WAIT waits indefinitely.
// STRUCTURE
// reservoir_seq_pkg: state enum typedef seq_state_t, state encodings, BLANK_CYCLES=1 constant.
// Sub-module reservoir_input_mask: mask register array, write port and combinational
// scaled-product output.
// TESTING
// 1 rst; mask[0..9]=8'h80, u=16'h1000, res_valid model 5 cycles -> res_din=32'h0800 on 10 res_en pulses.
// 2 reservoir model node states 1..10 -> out_data 1..10 in order, out_last only with 10.
// 3 clear_req and in_valid same cycle in IDLE -> 10 load pulses, sel 0..9, din 0; in_ready=0.
// 4 out_ready low 7 cycles mid-stream -> out_data/out_last stable, no skipped/duplicated node.
// 5 mask write during WAIT -> ignored; rst during WAIT -> res_en 0, out_valid 0, in_ready 1.
// 6 (RES_SEQ_TIMEOUT_EN) res_valid stuck 0 -> timeout_err=1 after 4096 cycles, state IDLE.

Source files
------------

// File: rtl/reservoir_seq_pkg.sv
// Shared types and constants for the reservoir front-end sequencer.
package reservoir_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_DRIVE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_READ  = 3'd4,
        ST_EMIT  = 3'd5
    } seq_state_t;

    // Cycles at the start of WAIT during which res_valid is still stale from
    // before the res_en pulse and must not be trusted.
    localparam int BLANK_CYCLES = 1;
    localparam int BLANK_W      = 2;

endpackage

// File: rtl/reservoir_input_mask.sv
// Per-virtual-node mask storage with a write port and the combinational
// scaled product (u * mask[rd_idx]) >> MASK_WIDTH.
module reservoir_input_mask
    import reservoir_seq_pkg::*;
#(
    parameter int NUM_VIRTUAL_NODES = 10,
    parameter int NW                = 4,
    parameter int INPUT_WIDTH       = 16,
    parameter int MASK_WIDTH        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [NW-1:0]          wr_addr,
    input  logic [MASK_WIDTH-1:0]  wr_data,
    input  logic [NW-1:0]          rd_idx,
    input  logic [INPUT_WIDTH-1:0] u,
    output logic [INPUT_WIDTH-1:0] scaled
);

    localparam int PW = INPUT_WIDTH + MASK_WIDTH;
    localparam logic [NW:0] NUM_EXT = (NW+1)'(NUM_VIRTUAL_NODES);

    logic [MASK_WIDTH-1:0] mask_q [NUM_VIRTUAL_NODES];
    logic [MASK_WIDTH-1:0] mask_d [NUM_VIRTUAL_NODES];
    logic [PW-1:0]         product;

    // Accept writes only to addresses that map onto a real node.
    always_comb begin
        mask_d = mask_q;
        if (wr_en && ({1'b0, wr_addr} < NUM_EXT)) begin
            mask_d[wr_addr] = wr_data;
        end
    end

    // Mask storage, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VIRTUAL_NODES; i++) begin
                mask_q[i] <= '0;
            end
        end else begin
            mask_q <= mask_d;
        end
    end

    assign product = {{MASK_WIDTH{1'b0}}, u} * {{INPUT_WIDTH{1'b0}}, mask_q[rd_idx]};
    assign scaled  = INPUT_WIDTH'(product >> MASK_WIDTH);

endmodule

// File: rtl/reservoir_sequencer.sv
// Front-end sequencer for the DFR reservoir: masks each sample per virtual
// node, drives the reservoir, then streams node states out. Optional WAIT
// watchdog enabled by defining RES_SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a sample or a clear request; mask writes accepted
// CLEAR | load zero into node idx, one node per cycle
// DRIVE | one-cycle res_en with masked sample for node idx
// WAIT  | blanking, then wait for res_valid before next node / readout
// READ  | select node idx, capture its state into out_*
// EMIT  | hold out_* until out_ready
module reservoir_sequencer
    import reservoir_seq_pkg::*;
#(
    parameter int NUM_VIRTUAL_NODES = 10,
    parameter int DATA_WIDTH        = 32,
    parameter int NODE_DATA_WIDTH   = 12,
    parameter int INPUT_WIDTH       = 16,
    parameter int MASK_WIDTH        = 8,
    parameter int TIMEOUT_CYCLES    = 4096,
    localparam int NW               = $clog2(NUM_VIRTUAL_NODES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INPUT_WIDTH-1:0]     in_data,
    input  logic                       clear_req,
    input  logic                       cfg_mask_we,
    input  logic [NW-1:0]              cfg_mask_addr,
    input  logic [MASK_WIDTH-1:0]      cfg_mask_data,
    input  logic [3:0]                 cfg_eta,
    output logic                       res_en,
    output logic [DATA_WIDTH-1:0]      res_din,
    output logic [3:0]                 res_eta,
    input  logic                       res_valid,
    output logic                       res_load_node,
    output logic [NODE_DATA_WIDTH-1:0] res_load_din,
    output logic [NW-1:0]              res_node_sel,
    input  logic [NODE_DATA_WIDTH-1:0] res_node_dout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NODE_DATA_WIDTH-1:0] out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam logic [NW-1:0] LAST_IDX = NW'(NUM_VIRTUAL_NODES - 1);

    seq_state_t                 state_q, state_d;
    logic [NW-1:0]              idx_q, idx_d;
    logic [INPUT_WIDTH-1:0]     u_q, u_d;
    logic [3:0]                 eta_q, eta_d;
    logic [BLANK_W-1:0]         blank_q, blank_d;
    logic                       out_valid_q, out_valid_d;
    logic [NODE_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                       out_last_q, out_last_d;
    logic                       mask_we;
    logic [INPUT_WIDTH-1:0]     scaled;
`ifdef RES_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]              wcnt_q, wcnt_d;
    logic                       err_q, err_d;
`endif

    reservoir_input_mask #(
        .NUM_VIRTUAL_NODES (NUM_VIRTUAL_NODES),
        .NW                (NW),
        .INPUT_WIDTH       (INPUT_WIDTH),
        .MASK_WIDTH        (MASK_WIDTH)
    ) u_mask (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (mask_we),
        .wr_addr (cfg_mask_addr),
        .wr_data (cfg_mask_data),
        .rd_idx  (idx_q),
        .u       (u_q),
        .scaled  (scaled)
    );

    // Next-state, index and output-register logic for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        u_d         = u_q;
        eta_d       = eta_q;
        blank_d     = blank_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        mask_we     = 1'b0;
`ifdef RES_SEQ_TIMEOUT_EN
        wcnt_d      = wcnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                mask_we = cfg_mask_we;
                if (clear_req) begin
                    idx_d   = '0;
                    state_d = ST_CLEAR;
                end else if (in_valid) begin
                    u_d     = in_data;
                    eta_d   = cfg_eta;
                    idx_d   = '0;
                    state_d = ST_DRIVE;
                end
            end
            ST_CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DRIVE: begin
                blank_d = BLANK_W'(BLANK_CYCLES);
`ifdef RES_SEQ_TIMEOUT_EN
                wcnt_d  = TW'(TIMEOUT_CYCLES - 1);
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (blank_q != '0) begin
                    blank_d = blank_q - 1'b1;
                end else if (res_valid) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_READ;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_DRIVE;
                    end
                end
`ifdef RES_SEQ_TIMEOUT_EN
                // Down-counter covers the whole WAIT, blanking included.
                if (!((blank_q == '0) && res_valid)) begin
                    if (wcnt_q == '0) begin
                        err_d   = 1'b1;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        wcnt_d = wcnt_q - 1'b1;
                    end
                end
`endif
            end
            ST_READ: begin
                out_data_d  = res_node_dout;
                out_valid_d = 1'b1;
                out_last_d  = (idx_q == LAST_IDX);
                state_d     = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            u_q         <= '0;
            eta_q       <= '0;
            blank_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
`ifdef RES_SEQ_TIMEOUT_EN
            wcnt_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            u_q         <= u_d;
            eta_q       <= eta_d;
            blank_q     <= blank_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
`ifdef RES_SEQ_TIMEOUT_EN
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready      = (state_q == ST_IDLE) && !clear_req;
    assign res_en        = (state_q == ST_DRIVE);
    assign res_din       = (state_q == ST_DRIVE) ?
                           {{(DATA_WIDTH-INPUT_WIDTH){1'b0}}, scaled} : '0;
    assign res_eta       = eta_q;
    assign res_load_node = (state_q == ST_CLEAR);
    assign res_load_din  = '0;
    assign res_node_sel  = idx_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_last      = out_last_q;
    assign busy          = (state_q != ST_IDLE);
`ifdef RES_SEQ_TIMEOUT_EN
    assign timeout_err   = err_q;
`else
    assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_reservoir_sequencer.sv
// Self-checking bench for reservoir_sequencer: table-driven sample runs with
// a scoreboard for res_din/res_eta, node loads and the output stream, plus
// hand-written clear, back-pressure, reset-abort and watchdog sequences.
module tb_reservoir_sequencer;

    localparam int N       = 10;
    localparam int RES_LAT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        clear_req;
    logic        cfg_mask_we;
    logic [3:0]  cfg_mask_addr;
    logic [7:0]  cfg_mask_data;
    logic [3:0]  cfg_eta;
    logic        res_en;
    logic [31:0] res_din;
    logic [3:0]  res_eta;
    logic        res_valid;
    logic        res_load_node;
    logic [11:0] res_load_din;
    logic [3:0]  res_node_sel;
    logic [11:0] res_node_dout;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_last;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    reservoir_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .clear_req     (clear_req),
        .cfg_mask_we   (cfg_mask_we),
        .cfg_mask_addr (cfg_mask_addr),
        .cfg_mask_data (cfg_mask_data),
        .cfg_eta       (cfg_eta),
        .res_en        (res_en),
        .res_din       (res_din),
        .res_eta       (res_eta),
        .res_valid     (res_valid),
        .res_load_node (res_load_node),
        .res_load_din  (res_load_din),
        .res_node_sel  (res_node_sel),
        .res_node_dout (res_node_dout),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    typedef struct { logic [31:0] din; logic [3:0] eta; } din_exp_t;
    typedef struct { logic [11:0] data; logic last; } out_exp_t;
    typedef struct {
        logic [15:0] u;
        logic [7:0]  mask;
        logic [3:0]  eta;
        logic [31:0] exp_din;
    } vec_t;

    din_exp_t   din_q[$];
    out_exp_t   out_q[$];
    logic [3:0] load_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] node_mem [16];
    int          rv_cnt    = 0;
    logic        res_stuck = 1'b0;
    logic        res_en_prev = 1'b0;

    assign res_node_dout = node_mem[res_node_sel];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reservoir model: busy for RES_LAT cycles after each res_en, zeroes nodes on load.
    always @(negedge clk) begin
        if (rst) begin
            rv_cnt    = 0;
            res_valid = 1'b1;
        end else begin
            if (res_en) begin
                res_valid = 1'b0;
                rv_cnt    = RES_LAT;
            end else if (rv_cnt > 0 && !res_stuck) begin
                rv_cnt--;
                if (rv_cnt == 0) res_valid = 1'b1;
            end
            if (res_load_node) node_mem[res_node_sel] = 12'h000;
        end
    end

    // Scoreboard monitor: compares DUT events against queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (res_en) begin
                chk("res_en_expected", 32'(din_q.size() != 0), 32'd1);
                chk("res_en_one_cycle", 32'(res_en_prev), 32'd0);
                if (din_q.size() != 0) begin
                    din_exp_t e;
                    e = din_q.pop_front();
                    chk("res_din", res_din, e.din);
                    chk("res_eta", 32'(res_eta), 32'(e.eta));
                end
            end
            if (out_valid && out_ready) begin
                chk("out_expected", 32'(out_q.size() != 0), 32'd1);
                if (out_q.size() != 0) begin
                    out_exp_t o;
                    o = out_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(o.data));
                    chk("out_last", 32'(out_last), 32'(o.last));
                end
            end
            if (res_load_node) begin
                chk("load_expected", 32'(load_q.size() != 0), 32'd1);
                chk("load_din", 32'(res_load_din), 32'd0);
                chk("load_in_ready", 32'(in_ready), 32'd0);
                if (load_q.size() != 0) begin
                    logic [3:0] s;
                    s = load_q.pop_front();
                    chk("load_sel", 32'(res_node_sel), 32'(s));
                end
            end
        end
        res_en_prev = res_en;
    end

    task automatic init_nodes();
        for (int i = 0; i < 16; i++) node_mem[i] = 12'(i + 1);
    endtask

    task automatic write_mask(input int addr, input logic [7:0] data);
        cfg_mask_we   = 1'b1;
        cfg_mask_addr = 4'(addr);
        cfg_mask_data = data;
        @(posedge clk); #1;
        cfg_mask_we   = 1'b0;
    endtask

    task automatic expect_run(input logic [31:0] base, input logic [31:0] step,
                              input logic [3:0] eta, input bit with_out);
        for (int i = 0; i < N; i++) begin
            din_q.push_back('{din: base + 32'(i) * step, eta: eta});
            if (with_out) out_q.push_back('{data: node_mem[i], last: (i == N - 1)});
        end
    endtask

    task automatic send_sample(input logic [15:0] u, input logic [3:0] eta);
        in_data  = u;
        cfg_eta  = eta;
        in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~u;
        cfg_eta  = ~eta;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int  n    = 0;
        bit  done = 1'b0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (!busy && din_q.size() == 0 && out_q.size() == 0 && load_q.size() == 0)
                done = 1'b1;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{u: 16'h1000, mask: 8'h80, eta: 4'h3, exp_din: 32'h0000_0800};
        vecs[1] = '{u: 16'hFFFF, mask: 8'hFF, eta: 4'hA, exp_din: 32'h0000_FEFF};
        vecs[2] = '{u: 16'h1234, mask: 8'h01, eta: 4'h1, exp_din: 32'h0000_0012};
        vecs[3] = '{u: 16'hABCD, mask: 8'h00, eta: 4'hF, exp_din: 32'h0000_0000};
        vecs[4] = '{u: 16'h8000, mask: 8'h40, eta: 4'h6, exp_din: 32'h0000_2000};

        init_nodes();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clear_req = 1'b0;
        cfg_mask_we = 1'b0; cfg_mask_addr = '0; cfg_mask_data = '0; cfg_eta = '0;
        out_ready = 1'b1; res_valid = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_en", 32'(res_en), 32'd0);
        chk("rst_res_din", res_din, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_load", 32'(res_load_node), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Uniform-mask sample runs from the vector table.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < N; i++) write_mask(i, vecs[v].mask);
            expect_run(vecs[v].exp_din, 32'd0, vecs[v].eta, 1'b1);
            send_sample(vecs[v].u, vecs[v].eta);
            wait_idle(2000, "table_run_done");
        end

        // Per-node masks; writes beyond the last node must not alias.
        for (int i = 0; i < N; i++) write_mask(i, 8'(i * 16));
        write_mask(10, 8'hFF);
        write_mask(15, 8'hFF);
        expect_run(32'd0, 32'd16, 4'h5, 1'b1);
        send_sample(16'h0100, 4'h5);
        wait_idle(2000, "pernode_run_done");

        // Clear wins over a simultaneous sample.
        clear_req = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h5555;
        for (int i = 0; i < N; i++) load_q.push_back(4'(i));
        @(negedge clk);
        chk("clear_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clear_req = 1'b0;
        in_valid  = 1'b0;
        wait_idle(200, "clear_done");
        init_nodes();

        // Back-pressure for 7 cycles mid-stream.
        for (int i = 0; i < N; i++) write_mask(i, 8'h80);
        expect_run(32'h800, 32'd0, 4'h2, 1'b1);
        send_sample(16'h1000, 4'h2);
        begin
            bit found = 1'b0;
            for (int n = 0; n < 500 && !found; n++) begin
                @(posedge clk); #1;
                if (out_valid && out_data == 12'd4) found = 1'b1;
            end
            chk("stall_reach_node4", 32'(found), 32'd1);
            out_ready = 1'b0;
            for (int c = 0; c < 7; c++) begin
                @(negedge clk);
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'd4);
                chk("stall_last", 32'(out_last), 32'd0);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
        wait_idle(2000, "stall_run_done");

        // Mask write while in WAIT is dropped.
        expect_run(32'h800, 32'd0, 4'h9, 1'b1);
        send_sample(16'h1000, 4'h9);
        @(posedge clk); #1;
        chk("in_wait_busy", 32'(busy), 32'd1);
        write_mask(1, 8'hFF);
        wait_idle(2000, "wait_write_run_done");

        // Reset during WAIT aborts the sample.
        expect_run(32'h800, 32'd0, 4'h4, 1'b1);
        send_sample(16'h1000, 4'h4);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        din_q.delete();
        out_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_res_en", 32'(res_en), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);

        // Reset cleared the mask RAM.
        @(posedge clk); #1;
        expect_run(32'd0, 32'd0, 4'h7, 1'b1);
        send_sample(16'h1000, 4'h7);
        wait_idle(2000, "post_reset_run_done");

`ifdef RES_SEQ_TIMEOUT_EN
        // Reservoir never returns valid: watchdog fires after TIMEOUT_CYCLES of WAIT.
        begin
            int busy_cycles = 0;
            bit idle_seen   = 1'b0;
            res_stuck = 1'b1;
            din_q.push_back('{din: 32'd0, eta: 4'h8});
            send_sample(16'h1000, 4'h8);
            for (int n = 0; n < 6000 && !idle_seen; n++) begin
                @(negedge clk);
                if (busy) busy_cycles++;
                else idle_seen = 1'b1;
            end
            chk("timeout_reached_idle", 32'(idle_seen), 32'd1);
            chk("timeout_busy_cycles", 32'(busy_cycles), 32'd4097);
            chk("timeout_err_set", 32'(timeout_err), 32'd1);
            chk("timeout_scoreboard_empty", 32'(din_q.size() + out_q.size()), 32'd0);
            repeat (20) @(negedge clk);
            chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
        end
`else
        chk("timeout_err_tied", 32'(timeout_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_time_limit actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
